pr_page_hub: RTL and testbench
==============================

// Module: pr_page_hub
// PURPOSE
//  Central responder for the page-value exchange between pageRank nodes. Accepts page requests
//  from NODES nodes and turns each into a query to the node owning that page. It then collects
//  that node's reply and returns it to the requester as a response {data,page_id}.
//  Arbitration is round-robin, with one transaction in flight. Sits between the node array and
//  the top level.
// PARAMETERS
//  NODES    4    number of pageRank nodes; owner of page p = p / PPN
//  PPN      16   pages per node (power of 2); PAGE_W = clog2(NODES*PPN) = 6
//  WIDTH    16   fixed-point value width (unsigned, 0.16 format)
//  FIFO_D   2    request FIFO depth per node (power of 2)
//  TIMEOUT  15   cycles to wait for a reply before an error response
// PORTS
//  clk          in   1               clock, rising edge
//  reset        in   1               asynchronous, active-low reset
//  req_valid    in   NODES           node n presents a request this cycle
//  req_page     in   NODES*PAGE_W    requested page id, node n at [n*PAGE_W+:PAGE_W]
//  req_ready    out  NODES           node n FIFO not full; request taken when valid&ready
//  query_valid  out  NODES           one-hot: owner node is being queried
//  query        out  PAGE_W          global page id being queried (same to all nodes)
//  reply_valid  in   NODES           owner node returns data
//  reply        in   NODES*WIDTH     reply data, node n at [n*WIDTH+:WIDTH]
//  resp_valid   out  NODES           one-hot: response to requester
//  response     out  WIDTH+PAGE_W    {data,page_id}, same to all nodes
//  resp_err     out  1               qualifies resp_valid: the reply timed out, data=0
// BEHAVIOUR
//  Reset, asserted asynchronously:
//   - all outputs go to 0, except req_ready = all ones
//   - FIFOs empty; FSM to IDLE; round-robin pointer to node 0
//   - any in-flight transaction is dropped with no response
//  Request FIFOs: one per node, FIFO_D entries.
//   - Push on req_valid & req_ready.
//   - req_ready is registered and is low when count == FIFO_D. It goes high the cycle after a pop.
//   - A push on a full FIFO cannot occur. Push and pop in the same cycle keep the count.
//  Arbiter:
//   - In IDLE, grants the first non-empty FIFO at or after ptr, searching upward and wrapping.
//   - On a grant, ptr = granted+1 mod NODES.
//  FSM (IDLE -> QUERY -> WAIT -> RESP -> IDLE):
//   - IDLE: when any FIFO is non-empty, pop the granted head. Latch src = granted node and
//     pg = head page; owner = pg / PPN.
//   - QUERY (1 cycle): query_valid[owner] = 1, query = pg. Clear timer.
//   - WAIT: sample reply[owner] when reply_valid[owner] = 1.
//     - reply_valid on other bits is ignored.
//     - reply_valid may arrive in the first WAIT cycle.
//     - timer++ each cycle; at timer == TIMEOUT, go to RESP with data = 0 and err = 1.
//   - RESP (1 cycle): resp_valid[src] = 1, response = {data,pg}, resp_err = err.
//  Latency: request accepted at cycle t gives a response at t+4 at the earliest (idle hub, reply
//  in the first WAIT cycle). Throughput: 1 transaction per 4 cycles at most.
//  Other rules:
//   - A self-query (owner == src) is legal and is handled the same way.
//   - query_valid, resp_valid and resp_err are registered.
//   - query and response hold their last value when not valid.
//   - Pages >= NODES*PPN cannot occur with PAGE_W = clog2(NODES*PPN); no range check.
// STRUCTURE
//  Package pr_noc_pkg:
//   - PAGE_W, NODE_W localparams
//   - state enum {IDLE,QUERY,WAIT,RESP}
//   - function pack_resp(data,page) returning {data,page}
//  Sub-module pr_rr_arbiter (#NODES): request vector + ptr in, one-hot grant + grant index out;
//  purely combinational.
//  Top: FIFO instances via generate, FSM, timer, output registers.
// TESTING
//  1. Reset low, then release. -> req_ready = 4'b1111 and all valids 0. Hold reset for 3 cycles.
//  2. Node 1 requests page 0x23; node 2 replies 0x1234 on the first WAIT cycle.
//     -> query_valid = 4'b0100, query = 0x23; resp_valid = 4'b0010, response = {0x1234,0x23}
//     at t+4, resp_err = 0.
//  3. Nodes 0..3 all request in the same cycle, ptr = 0. -> responses arrive in order
//     0,1,2,3, spaced 4 cycles apart (for immediate replies).
//     Then repeat with ptr = 2 -> order 2,3,0,1.
//  4. Node 3 requests page 0x05, node 0 never replies.
//     -> resp_valid = 4'b1000, response = {0x0000,0x05}, resp_err = 1, TIMEOUT+3 cycles after
//     acceptance.
//  5. Node 0 pushes 3 requests back-to-back while the hub is busy. -> req_ready[0] drops after
//     2 pushes. The third request is held and is accepted after the first pop. Responses come
//     back in FIFO order.
//  6. Drop reset in WAIT. -> outputs clear immediately. The late reply_valid is ignored.
//     No resp_valid pulse follows.

Source files
------------

// File: rtl/pr_noc_pkg.sv
// rtl/pr_noc_pkg.sv - shared widths, FSM states and response packing for the page hub
package pr_noc_pkg;
  localparam int NODES_DEF = 4;
  localparam int PPN_DEF   = 16;
  localparam int DATA_W    = 16;
  localparam int PAGE_W    = $clog2(NODES_DEF * PPN_DEF);
  localparam int NODE_W    = $clog2(NODES_DEF);

  typedef enum logic [1:0] {IDLE, QUERY, WAIT, RESP} state_e;

  function automatic logic [DATA_W+PAGE_W-1:0] pack_resp(input logic [DATA_W-1:0] data,
                                                         input logic [PAGE_W-1:0] page);
    return {data, page};
  endfunction
endpackage

// File: rtl/pr_rr_arbiter.sv
// rtl/pr_rr_arbiter.sv - round-robin grant: first requester at or after the pointer, wrapping
module pr_rr_arbiter #(
  parameter int NODES  = 4,
  parameter int NODE_W = 2
) (
  input  logic [NODES-1:0]  i_req,
  input  logic [NODE_W-1:0] i_ptr,
  output logic [NODES-1:0]  o_grant,
  output logic [NODE_W-1:0] o_idx
);
  logic              w_found;
  logic [NODE_W-1:0] w_j;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_j     = '0;
    for (int k = 0; k < NODES; k++) begin
      w_j = NODE_W'((int'(i_ptr) + k) % NODES);
      if (!w_found && i_req[w_j]) begin
        w_found    = 1'b1;
        o_grant[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end
endmodule

// File: rtl/pr_page_hub.sv
// rtl/pr_page_hub.sv - page-value hub: per-node request FIFOs, round-robin pick, query/reply FSM
module pr_page_hub
  import pr_noc_pkg::*;
#(
  parameter int NODES   = NODES_DEF,
  parameter int PPN     = PPN_DEF,
  parameter int WIDTH   = DATA_W,
  parameter int FIFO_D  = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [NODES-1:0]         i_req_valid,
  input  logic [NODES*PAGE_W-1:0]  i_req_page,
  output logic [NODES-1:0]         o_req_ready,
  output logic [NODES-1:0]         o_query_valid,
  output logic [PAGE_W-1:0]        o_query,
  input  logic [NODES-1:0]         i_reply_valid,
  input  logic [NODES*WIDTH-1:0]   i_reply,
  output logic [NODES-1:0]         o_resp_valid,
  output logic [WIDTH+PAGE_W-1:0]  o_response,
  output logic                     o_resp_err
);
  localparam int AW    = $clog2(FIFO_D);
  localparam int PPN_W = $clog2(PPN);
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(FIFO_D);

  state_e                  r_state;
  logic [NODE_W-1:0]       r_ptr, r_src, w_gidx, w_ptr_nxt, w_head_owner, w_owner;
  logic [PAGE_W-1:0]       r_pg, w_head_pg, r_query;
  logic [TMR_W-1:0]        r_timer, w_tmr_nxt;
  logic [NODES-1:0]        w_nonempty, w_grant, w_pop, r_query_valid, r_resp_valid;
  logic [WIDTH+PAGE_W-1:0] r_response;
  logic                    r_resp_err;
  logic [PAGE_W-1:0]       w_head  [NODES];
  logic [WIDTH-1:0]        w_reply [NODES];

  for (genvar n = 0; n < NODES; n++) begin : g_fifo
    logic [PAGE_W-1:0] r_mem [FIFO_D];
    logic [AW-1:0]     r_wr, r_rd;
    logic [AW:0]       r_cnt, w_cnt_nxt;
    logic              r_ready, w_push;

    assign w_push    = i_req_valid[n] & r_ready;
    assign w_cnt_nxt = r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop[n]};

    // ready is registered from the next count so it reopens the cycle after a pop
    always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
        r_wr    <= '0;
        r_rd    <= '0;
        r_cnt   <= '0;
        r_ready <= 1'b1;
      end else begin
        if (w_push)   r_wr <= r_wr + 1'b1;
        if (w_pop[n]) r_rd <= r_rd + 1'b1;
        r_cnt   <= w_cnt_nxt;
        r_ready <= (w_cnt_nxt != CNT_FULL);
      end
    end

    always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr] <= i_req_page[n*PAGE_W +: PAGE_W];
    end

    assign w_nonempty[n]  = (r_cnt != '0);
    assign w_head[n]      = r_mem[r_rd];
    assign w_reply[n]     = i_reply[n*WIDTH +: WIDTH];
    assign o_req_ready[n] = r_ready;
  end

  pr_rr_arbiter #(.NODES(NODES), .NODE_W(NODE_W)) u_arb (
    .i_req   (w_nonempty),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gidx)
  );

  assign w_pop        = (r_state == IDLE) ? w_grant : '0;
  assign w_head_pg    = w_head[w_gidx];
  assign w_head_owner = w_head_pg[PPN_W +: NODE_W];
  assign w_owner      = r_pg[PPN_W +: NODE_W];
  assign w_ptr_nxt    = (w_gidx == NODE_W'(NODES - 1)) ? '0 : w_gidx + 1'b1;
  assign w_tmr_nxt    = r_timer + 1'b1;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state       <= IDLE;
      r_ptr         <= '0;
      r_src         <= '0;
      r_pg          <= '0;
      r_timer       <= '0;
      r_query_valid <= '0;
      r_query       <= '0;
      r_resp_valid  <= '0;
      r_response    <= '0;
      r_resp_err    <= 1'b0;
    end else begin
      r_query_valid <= '0;
      r_resp_valid  <= '0;
      r_resp_err    <= 1'b0;
      case (r_state)
        IDLE: if (|w_nonempty) begin
          r_src         <= w_gidx;
          r_pg          <= w_head_pg;
          r_ptr         <= w_ptr_nxt;
          r_query_valid <= NODES'(1) << w_head_owner;
          r_query       <= w_head_pg;
          r_state       <= QUERY;
        end
        QUERY: begin
          r_timer <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          r_timer <= w_tmr_nxt;
          // only the owner's reply_valid bit counts; a reply on the last cycle beats the timeout
          if (i_reply_valid[w_owner] || (w_tmr_nxt == TMR_W'(TIMEOUT))) begin
            r_resp_valid <= NODES'(1) << r_src;
            r_resp_err   <= !i_reply_valid[w_owner];
            r_response   <= pack_resp(i_reply_valid[w_owner] ? w_reply[w_owner] : '0, r_pg);
            r_state      <= RESP;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_query_valid = r_query_valid;
  assign o_query       = r_query;
  assign o_resp_valid  = r_resp_valid;
  assign o_response    = r_response;
  assign o_resp_err    = r_resp_err;
endmodule

// File: tb/tb_pr_page_hub.sv
// tb/tb_pr_page_hub.sv - scoreboard bench for pr_page_hub with a scripted node responder
module tb_pr_page_hub;
  localparam int N  = 4;
  localparam int PW = 6;
  localparam int W  = 16;
  localparam int TO = 15;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*PW-1:0] req_page = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    query_valid;
  logic [PW-1:0]   query;
  logic [N-1:0]    reply_valid = '0;
  logic [N*W-1:0]  reply = '0;
  logic [N-1:0]    resp_valid;
  logic [W+PW-1:0] response;
  logic            resp_err;

  pr_page_hub dut (
    .i_clk         (clk),
    .i_reset       (rst_n),
    .i_req_valid   (req_valid),
    .i_req_page    (req_page),
    .o_req_ready   (req_ready),
    .o_query_valid (query_valid),
    .o_query       (query),
    .i_reply_valid (reply_valid),
    .i_reply       (reply),
    .o_resp_valid  (resp_valid),
    .o_response    (response),
    .o_resp_err    (resp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct { logic [N-1:0] vld; logic [W+PW-1:0] resp; logic err; int cy; } rexp_t;
  typedef struct { logic [N-1:0] vld; logic [PW-1:0] pg; } qexp_t;
  rexp_t rq[$];
  qexp_t qq[$];
  rexp_t re;
  qexp_t qe;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rdata(input logic [PW-1:0] p);
    return (p == 6'h23) ? 16'h1234 : {10'h2A5, p};
  endfunction

  // reply delay in WAIT cycles per page; -1 means the owner never answers
  function automatic int rdelay(input logic [PW-1:0] p);
    case (p)
      6'h05:   return -1;
      6'h30:   return 6;
      6'h10:   return 3;
      default: return 0;
    endcase
  endfunction

  task automatic expect_txn(input int src, input logic [PW-1:0] p, input int cy);
    qexp_t q;
    rexp_t r;
    logic err;
    err   = (rdelay(p) < 0);
    q.vld = N'(1) << p[5:4];
    q.pg  = p;
    r.vld = N'(1) << src;
    r.resp = {(err ? 16'h0000 : rdata(p)), p};
    r.err = err;
    r.cy  = cy;
    qq.push_back(q);
    rq.push_back(r);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (|resp_valid) begin
        if (rq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL resp_unexpected actual=%0h required=none", resp_valid);
        end else begin
          re = rq.pop_front();
          check("resp_valid", resp_valid, re.vld);
          check("response", response, re.resp);
          check("resp_err", resp_err, re.err);
          if (re.cy != 0) check("resp_cycle", cyc, re.cy);
        end
      end
      if (|query_valid) begin
        if (qq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL query_unexpected actual=%0h required=none", query_valid);
        end else begin
          qe = qq.pop_front();
          check("query_valid", query_valid, qe.vld);
          check("query", query, qe.pg);
        end
      end
    end
  end

  int rs_own, rs_d;
  logic [PW-1:0] rs_pg;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && |query_valid) begin
        rs_own = 0;
        for (int i = 0; i < N; i++) if (query_valid[i]) rs_own = i;
        rs_pg = query;
        rs_d  = rdelay(rs_pg);
        if (rs_d >= 0) begin
          @(posedge clk); #1;
          if (rs_d > 0) begin
            reply_valid[(rs_own + 1) % N] = 1'b1;
            reply[((rs_own + 1) % N)*W +: W] = 16'hDEAD;
          end
          repeat (rs_d) begin
            @(posedge clk); #1;
            reply_valid = '0;
          end
          reply_valid[rs_own] = 1'b1;
          reply[rs_own*W +: W] = rdata(rs_pg);
          @(posedge clk); #1;
          reply_valid = '0;
        end
      end
    end
  end

  task automatic send(input int n, input logic [PW-1:0] p, output int acc);
    acc = 0;
    req_page[n*PW +: PW] = p;
    req_valid[n] = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (req_ready[n]) begin
        acc = cyc;
        break;
      end
    end
    @(posedge clk); #1;
    req_valid[n] = 1'b0;
    if (acc == 0) check("send_accept_timeout", 0, 1);
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (rq.size() == 0 && qq.size() == 0) break;
    end
    if (k == 200) check("drain_timeout", rq.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic burst(input logic [N*PW-1:0] pages, input int order[4]);
    int a;
    req_page  = pages;
    req_valid = '1;
    @(negedge clk);
    check("burst_ready", req_ready, 4'b1111);
    a = cyc;
    for (int k = 0; k < 4; k++)
      expect_txn(order[k], pages[order[k]*PW +: PW], a + 4 + 4*k);
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  logic [PW-1:0] pg5 [3] = '{6'h3A, 6'h0B, 6'h1C};
  int c;

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 4'b1111);
    check("rst_query_valid", query_valid, 0);
    check("rst_resp_valid", resp_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", req_ready, 4'b1111);
    check("post_rst_resp_err", resp_err, 0);
    check("post_rst_response", response, 0);
    @(posedge clk); #1;

    // all four at once, pointer at 0
    burst({6'h02, 6'h3F, 6'h2C, 6'h11}, '{0, 1, 2, 3});
    drain();

    // single request with immediate reply, moves pointer to 2
    send(1, 6'h23, c);
    expect_txn(1, 6'h23, c + 4);
    drain();

    // all four at once, pointer at 2
    burst({6'h38, 6'h25, 6'h1A, 6'h07}, '{2, 3, 0, 1});
    drain();

    // owner never replies
    send(3, 6'h05, c);
    expect_txn(3, 6'h05, c + TO + 3);
    drain();

    // FIFO fills while the hub waits on a slow owner
    send(2, 6'h30, c);
    expect_txn(2, 6'h30, c + 10);
    req_valid[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_page[PW-1:0] = pg5[k];
      if (k == 2) begin
        @(negedge clk);
        check("fifo_full_ready", req_ready[0], 0);
      end
      for (int t = 0; t < 100; t++) begin
        @(negedge clk);
        if (req_ready[0]) break;
      end
      expect_txn(0, pg5[k], 0);
      @(posedge clk); #1;
    end
    req_valid[0] = 1'b0;
    drain();

    // reset while waiting for a reply
    send(1, 6'h10, c);
    qe.vld = 4'b0010;
    qe.pg  = 6'h10;
    qq.push_back(qe);
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("wait_rst_query_valid", query_valid, 0);
    check("wait_rst_query", query, 0);
    check("wait_rst_resp_valid", resp_valid, 0);
    check("wait_rst_req_ready", req_ready, 4'b1111);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;

    check("queues_empty", rq.size() + qq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
